// File: rtl/anffl_tex_texel_fetch.sv
// anffl_tex_texel_fetch
// Texel fetch stage that sits after the texture address generator. One request
// (byte address + 5-bit format) is accepted at a time. The block issues one
// 32-bit word read, or two reads when a 24-bit texel straddles a word boundary,
// and returns the texel unpacked to RGBA8888. Compressed or undefined formats
// and misaligned 16/32-bit addresses return err=1 without touching memory.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_addr[31:0], req_format[4:0] texel byte address and format code
//   mem_rd_valid/mem_rd_ready     word read request handshake
//   mem_rd_addr[MEM_AW-1:0]       word address (byte address bits [MEM_AW+1:2])
//   mem_rsp_valid, mem_rsp_data   in-order read data, one-cycle pulse
//   texel_valid/texel_ready       result handshake
//   texel_rgba[31:0]              {A,B,G,R}
//   texel_err                     qualifies texel_valid: unsupported/misaligned
module anffl_tex_texel_fetch #(
    parameter int MEM_AW = 30   // at most 30: word address comes from addr[31:2]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [4:0]        req_format,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              texel_valid,
    input  logic              texel_ready,
    output logic [31:0]       texel_rgba,
    output logic              texel_err
);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_WAIT0, S_RD1, S_WAIT1, S_OUT} state_t;

    // Formats collapse onto a handful of unpack layouts; aliased codes share one.
    typedef enum logic [3:0] {
        K_NONE, K_RGB24, K_RGBA32, K_565, K_4444, K_555, K_5551, K_R8, K_R16
    } kind_t;

    function automatic kind_t fmt_kind(input logic [4:0] f);
        case (f)
            5'b00000, 5'b00011: return K_RGB24;
            5'b00100, 5'b00111: return K_RGBA32;
            5'b00001, 5'b01011: return K_565;
            5'b00101, 5'b01111: return K_4444;
            5'b01001:           return K_555;
            5'b01101:           return K_5551;
            5'b10011:           return K_R8;
            5'b10111:           return K_R16;
            default:            return K_NONE;   // compressed and undefined codes
        endcase
    endfunction

    function automatic logic [7:0] exp4(input logic [3:0] x);
        return {x, x};
    endfunction

    function automatic logic [7:0] exp5(input logic [4:0] x);
        return {x, x[4:2]};
    endfunction

    function automatic logic [7:0] exp6(input logic [5:0] x);
        return {x, x[5:4]};
    endfunction

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_addr;
    kind_t             r_kind;
    logic [31:0]       r_word0;
    logic [31:0]       r_rgba;
    logic              r_err;

    kind_t             w_req_kind;
    logic              w_req_is16;
    logic              w_req_bad;
    logic              w_split;
    logic [MEM_AW-1:0] w_word_addr;
    logic [31:0]       w_lo;
    logic [31:0]       w_hi;
    logic [7:0]        w_stream [8];
    logic [7:0]        w_byte   [4];
    logic [15:0]       w_h;
    logic [31:0]       w_rgba;

    assign w_req_kind  = fmt_kind(req_format);
    assign w_req_is16  = (w_req_kind == K_565) || (w_req_kind == K_4444) ||
                         (w_req_kind == K_555) || (w_req_kind == K_5551) ||
                         (w_req_kind == K_R16);
    assign w_req_bad   = (w_req_kind == K_NONE) ||
                         ((w_req_kind == K_RGBA32) && (req_addr[1:0] != 2'b00)) ||
                         (w_req_is16 && req_addr[0]);
    // Only a 24-bit texel starting at byte 2 or 3 runs past the first word.
    assign w_split     = (r_kind == K_RGB24) && r_addr[1];
    assign w_word_addr = r_addr[MEM_AW+1:2];

    // The final word arrives on mem_rsp_data, so decode straight from the bus
    // and register only the finished texel.
    assign w_lo = (r_state == S_WAIT1) ? r_word0      : mem_rsp_data;
    assign w_hi = (r_state == S_WAIT1) ? mem_rsp_data : 32'h0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign w_stream[gi]     = w_lo[8*gi +: 8];
            assign w_stream[gi + 4] = w_hi[8*gi +: 8];
            assign w_byte[gi]       = w_stream[3'(gi) + {1'b0, r_addr[1:0]}];
        end
    endgenerate

    assign w_h = {w_byte[1], w_byte[0]};

    always_comb begin
        w_rgba = 32'h0;
        case (r_kind)
            K_RGB24:  w_rgba = {8'hFF, w_byte[2], w_byte[1], w_byte[0]};
            K_RGBA32: w_rgba = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
            K_565:    w_rgba = {8'hFF, exp5(w_h[4:0]), exp6(w_h[10:5]), exp5(w_h[15:11])};
            K_4444:   w_rgba = {exp4(w_h[3:0]), exp4(w_h[7:4]), exp4(w_h[11:8]), exp4(w_h[15:12])};
            K_555:    w_rgba = {8'hFF, exp5(w_h[4:0]), exp5(w_h[9:5]), exp5(w_h[14:10])};
            K_5551:   w_rgba = {(w_h[0] ? 8'hFF : 8'h00), exp5(w_h[5:1]), exp5(w_h[10:6]),
                                exp5(w_h[15:11])};
            K_R8:     w_rgba = {8'hFF, 16'h0, w_byte[0]};
            K_R16:    w_rgba = {8'hFF, 16'h0, w_h[15:8]};
            default:  w_rgba = 32'h0;
        endcase
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_addr  = '0;
        texel_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;   // held low while reset is being applied
                if (req_valid) w_state_next = w_req_bad ? S_OUT : S_RD0;
            end
            S_RD0: begin
                mem_rd_valid = 1'b1;
                mem_rd_addr  = w_word_addr;
                if (mem_rd_ready) w_state_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_rsp_valid) w_state_next = w_split ? S_RD1 : S_OUT;
            end
            S_RD1: begin
                mem_rd_valid = 1'b1;
                mem_rd_addr  = w_word_addr + MEM_AW'(1);   // wraps at 2^MEM_AW
                if (mem_rd_ready) w_state_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rsp_valid) w_state_next = S_OUT;
            end
            S_OUT: begin
                texel_valid = 1'b1;
                if (texel_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_kind  <= K_NONE;
            r_word0 <= 32'h0;
            r_rgba  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr <= req_addr;
                        r_kind <= w_req_kind;
                        r_err  <= w_req_bad;
                        r_rgba <= 32'h0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rsp_valid) begin
                        r_word0 <= mem_rsp_data;
                        if (!w_split) r_rgba <= w_rgba;
                    end
                end
                S_WAIT1: begin
                    if (mem_rsp_valid) r_rgba <= w_rgba;
                end
                default: ;
            endcase
        end
    end

    assign texel_rgba = (r_state == S_OUT) ? r_rgba : 32'h0;
    assign texel_err  = (r_state == S_OUT) ? r_err  : 1'b0;

endmodule
